// File: rtl/ad7264_spi_master_if.sv
// ad7264_spi_master_if: frame control, ADC pins and result bus of the AD7264 SPI master.
interface ad7264_spi_master_if;
    logic        start;
    logic        continuous;
    logic [15:0] cfg_word;
    logic        MISOA;
    logic        MISOB;
    logic        SCLK;
    logic        SS;
    logic        MOSI;
    logic        busy;
    logic        done;
    logic [13:0] data_a;
    logic [13:0] data_b;

    modport master (
        input  start, continuous, cfg_word, MISOA, MISOB,
        output SCLK, SS, MOSI, busy, done, data_a, data_b
    );

    modport slave (
        output start, continuous, cfg_word, MISOA, MISOB,
        input  SCLK, SS, MOSI, busy, done, data_a, data_b
    );
endinterface

// File: rtl/ad7264_spi_master.sv
// ad7264_spi_master: sequences one 33-period AD7264 frame (16-bit config out, dual 14-bit capture).
module ad7264_spi_master #(
    parameter int CLK_DIV  = 4,
    parameter int IDLE_GAP = 4
) (
    input logic                 clk,
    input logic                 resetn,
    ad7264_spi_master_if.master bus
);
    // The idle cycle before the next SS fall counts toward the gap, so TRAIL is one shorter.
    localparam int TRAIL_N = (IDLE_GAP > 1) ? IDLE_GAP - 1 : 1;
    localparam int MAXC    = (CLK_DIV > TRAIL_N) ? CLK_DIV : TRAIL_N;
    localparam int CW      = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, LEAD, LOW, HIGH, TRAIL} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    p_q, p_d;
    logic [14:0]   sh_q, sh_d;
    logic [13:0]   cap_a_q, cap_a_d, cap_b_q, cap_b_d;
    logic [13:0]   data_a_q, data_a_d, data_b_q, data_b_d;
    logic          sclk_q, sclk_d, ss_q, ss_d, mosi_q, mosi_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic          half_end, trail_end;

    assign half_end  = cnt_q == CW'(CLK_DIV - 1);
    assign trail_end = cnt_q == CW'(TRAIL_N - 1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            p_q      <= '0;
            sh_q     <= '0;
            cap_a_q  <= '0;
            cap_b_q  <= '0;
            data_a_q <= '0;
            data_b_q <= '0;
            sclk_q   <= 1'b1;
            ss_q     <= 1'b1;
            mosi_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            sh_q     <= sh_d;
            cap_a_q  <= cap_a_d;
            cap_b_q  <= cap_b_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            sclk_q   <= sclk_d;
            ss_q     <= ss_d;
            mosi_q   <= mosi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        p_d      = p_q;
        sh_d     = sh_q;
        cap_a_d  = cap_a_q;
        cap_b_d  = cap_b_q;
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        sclk_d   = sclk_q;
        ss_d     = ss_q;
        mosi_d   = mosi_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.start || bus.continuous) begin
                    state_d = LEAD;
                    ss_d    = 1'b0;
                    busy_d  = 1'b1;
                    mosi_d  = bus.cfg_word[15];
                    sh_d    = bus.cfg_word[14:0];
                    p_d     = 6'd1;
                    cap_a_d = '0;
                    cap_b_d = '0;
                end
            end
            LEAD: if (half_end) begin
                state_d = LOW;
                sclk_d  = 1'b0;
                cnt_d   = '0;
            end
            LOW: if (half_end) begin
                state_d = HIGH;
                sclk_d  = 1'b1;
                cnt_d   = '0;
                mosi_d  = (p_q <= 6'd15) ? sh_q[14] : 1'b0;
                sh_d    = {sh_q[13:0], 1'b0};
                if (p_q >= 6'd19 && p_q <= 6'd32) begin
                    cap_a_d = {cap_a_q[12:0], bus.MISOA};
                    cap_b_d = {cap_b_q[12:0], bus.MISOB};
                end
            end
            HIGH: if (half_end) begin
                cnt_d = '0;
                if (p_q < 6'd33) begin
                    state_d = LOW;
                    sclk_d  = 1'b0;
                    p_d     = p_q + 6'd1;
                end else begin
                    state_d  = TRAIL;
                    ss_d     = 1'b1;
                    done_d   = 1'b1;
                    data_a_d = cap_a_q;
                    data_b_d = cap_b_q;
                end
            end
            TRAIL: if (trail_end) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.SCLK   = sclk_q;
    assign bus.SS     = ss_q;
    assign bus.MOSI   = mosi_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.data_a = data_a_q;
    assign bus.data_b = data_b_q;
endmodule

// File: tb/tb_ad7264_spi_master.sv
// tb_ad7264_spi_master: directed frames against an AD7264 slave emulator, scoreboard-checked at done.
module tb_ad7264_spi_master;
    typedef struct {
        logic [15:0] cfg;
        logic [13:0] a;
        logic [13:0] b;
    } exp_t;
    typedef struct {
        logic [13:0] a;
        logic [13:0] b;
    } slv_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    ad7264_spi_master_if bus ();

    ad7264_spi_master #(.CLK_DIV(2), .IDLE_GAP(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    slv_t slv_q[$];
    slv_t cur;
    int   sk = 0;
    int   n_done = 0;
    int   ss_low, falls, rises, hi_cnt, gap;
    logic [15:0] rx;
    logic prev_ss = 1'b1, prev_sclk = 1'b1, glitch = 1'b0;
    logic [13:0] prev_a, prev_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Slave emulator: updates MISO on falling SCLK, bit 13 at period 19 down to bit 0 at period 32.
    always @(negedge bus.SCLK or posedge bus.SS) begin
        if (bus.SS) sk = 0;
        else begin
            if (sk == 0) begin
                if (slv_q.size() > 0) cur = slv_q.pop_front();
                else cur = '{a: 14'h0, b: 14'h0};
            end
            sk++;
            if (sk >= 19 && sk <= 32) begin
                bus.MISOA = cur.a[32-sk];
                bus.MISOB = cur.b[32-sk];
            end else begin
                bus.MISOA = 1'b1;
                bus.MISOB = 1'b1;
            end
        end
    end

    // Monitor: measures each frame and compares against the scoreboard at every done.
    always @(negedge clk) begin
        if (!resetn) begin
            glitch    = 1'b0;
            prev_ss   = 1'b1;
            prev_sclk = 1'b1;
            prev_a    = bus.data_a;
            prev_b    = bus.data_b;
        end else begin
            if (!bus.SS && prev_ss) begin
                ss_low = 0;
                falls  = 0;
                rises  = 0;
                rx     = '0;
                gap    = hi_cnt;
            end
            if (bus.done) hi_cnt = 0;
            if (bus.SS) hi_cnt++;
            if (!bus.SS) begin
                ss_low++;
                if (prev_sclk && !bus.SCLK) begin
                    falls++;
                    if (falls <= 16) rx = {rx[14:0], bus.MOSI};
                end
                if (!prev_sclk && bus.SCLK) rises++;
            end
            if (!bus.done && (bus.data_a !== prev_a || bus.data_b !== prev_b)) glitch = 1'b1;
            if (bus.done) begin
                n_done++;
                if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("data_a", 32'(bus.data_a), 32'(e.a));
                    chk("data_b", 32'(bus.data_b), 32'(e.b));
                    chk("mosi_word", 32'(rx), 32'(e.cfg));
                    chk("ss_low_clk", ss_low, 134);
                    chk("sclk_falls", falls, 33);
                    chk("sclk_rises", rises, 33);
                    chk("data_stable_between_done", 32'(glitch), 32'd0);
                end
                glitch = 1'b0;
            end
            prev_ss   = bus.SS;
            prev_sclk = bus.SCLK;
            prev_a    = bus.data_a;
            prev_b    = bus.data_b;
        end
    end

    task automatic push(input logic [15:0] cfg, input logic [13:0] a, input logic [13:0] b);
        exp_q.push_back('{cfg: cfg, a: a, b: b});
        slv_q.push_back('{a: a, b: b});
    endtask

    task automatic pulse_start();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (n_done < target && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("done_timeout", 32'(n_done >= target), 32'd1);
    endtask

    task automatic wait_ss(input logic lvl, input string name);
        int k = 0;
        while (bus.SS !== lvl && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(bus.SS), 32'(lvl));
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus.busy !== 1'b0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("busy_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic wait_sk(input int n);
        int k = 0;
        while (sk < n && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("period_timeout", 32'(sk >= n), 32'd1);
    endtask

    task automatic chk_idle_pins(input string tag);
        chk({tag, "_sclk"}, 32'(bus.SCLK), 32'd1);
        chk({tag, "_ss"}, 32'(bus.SS), 32'd1);
        chk({tag, "_mosi"}, 32'(bus.MOSI), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_data_a"}, 32'(bus.data_a), 32'd0);
        chk({tag, "_data_b"}, 32'(bus.data_b), 32'd0);
    endtask

    initial begin
        int d0;
        bus.start      = 1'b0;
        bus.continuous = 1'b0;
        bus.cfg_word   = 16'h0;
        repeat (4) @(negedge clk);
        chk_idle_pins("reset");
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        // Single frame
        bus.cfg_word = 16'hA5C3;
        push(16'hA5C3, 14'h2ABC, 14'h1555);
        pulse_start();
        bus.cfg_word = 16'h0000;
        wait_done(1);
        wait_idle();

        // Start while busy is ignored and not queued
        bus.cfg_word = 16'h1234;
        push(16'h1234, 14'h0123, 14'h3210);
        d0 = n_done;
        pulse_start();
        wait_ss(1'b0, "ss_fall_timeout");
        repeat (50) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        wait_idle();
        chk("one_done_per_frame", n_done - d0, 1);
        repeat (10) @(negedge clk);
        chk("start_not_queued", 32'(bus.SS), 32'd1);
        bus.cfg_word = 16'h8001;
        push(16'h8001, 14'h3FFF, 14'h0000);
        pulse_start();
        wait_done(d0 + 2);
        wait_idle();

        // Continuous back-to-back frames
        d0 = n_done;
        bus.cfg_word = 16'h0F0F;
        push(16'h0F0F, 14'h1A2B, 14'h0C3D);
        push(16'hF0F0, 14'h2468, 14'h1357);
        @(negedge clk) bus.continuous = 1'b1;
        wait_ss(1'b0, "ss_fall_timeout");
        bus.cfg_word = 16'hF0F0;
        wait_done(d0 + 1);
        wait_ss(1'b0, "ss_refall_timeout");
        bus.continuous = 1'b0;
        wait_done(d0 + 2);
        chk("ss_gap_clk", gap, 4);
        wait_idle();
        repeat (10) @(negedge clk);
        chk("no_third_frame", 32'(bus.SS), 32'd1);

        // Reset mid-frame
        d0 = n_done;
        bus.cfg_word = 16'hC3C3;
        slv_q.push_back('{a: 14'h3FFF, b: 14'h3FFF});
        pulse_start();
        wait_sk(20);
        resetn = 1'b0;
        #1;
        chk_idle_pins("abort");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_done_on_abort", n_done - d0, 0);
        bus.cfg_word = 16'h5A5A;
        push(16'h5A5A, 14'h0001, 14'h2000);
        pulse_start();
        wait_done(d0 + 1);
        wait_idle();

        // Config word latched at frame start
        bus.cfg_word = 16'h0000;
        push(16'h0000, 14'h1111, 14'h2222);
        pulse_start();
        wait_sk(5);
        bus.cfg_word = 16'hFFFF;
        wait_done(d0 + 2);
        wait_idle();

        repeat (5) @(negedge clk);
        chk("exp_queue_empty", exp_q.size(), 0);
        chk("total_done", n_done, 7);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
